// File: rtl/pll_rs_reset_ctrl.sv
// pll_rs_reset_ctrl: sequences the PLL reset, waits for a stable synchronized lock and only then
// releases the RS core. Optional macro RSTCTRL_MAX_RETRY_EN adds a terminal FAIL state.
module pll_rs_reset_ctrl #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 100000,
  parameter int LOCK_STABLE_CYC  = 256,
  parameter int SYNC_STAGES      = 2,
  parameter int MAX_RETRY        = 8
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       pll_ready,
  output logic       lock_lost,
  output logic [7:0] retry_cnt,
  output logic       fail
);

  localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
  localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN
`ifdef RSTCTRL_MAX_RETRY_EN
    , S_FAIL
`endif
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [7:0]             retry_reg, retry_next, retry_sat;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   locked_s;

  logic pll_rst_reg, pll_rst_next;
  logic sys_rst_reg, sys_rst_next;
  logic pll_ready_reg, pll_ready_next;
  logic lock_lost_reg, lock_lost_next;

  // locked is asynchronous to refclk; only the last stage of this chain is ever used.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], locked};
    end
  end

  assign locked_s  = sync_reg[SYNC_STAGES-1];
  assign retry_sat = (retry_reg == 8'hFF) ? retry_reg : retry_reg + 8'd1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    case (state_reg)
      S_PLL_RST: begin
        if (cnt_reg == PULSE_LAST) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (locked_s) begin
          state_next = S_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          cnt_next   = '0;
          retry_next = retry_sat;
`ifdef RSTCTRL_MAX_RETRY_EN
          state_next = ({24'd0, retry_sat} == 32'(MAX_RETRY)) ? S_FAIL : S_PLL_RST;
`else
          state_next = S_PLL_RST;
`endif
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_next = S_PLL_RST;
          cnt_next   = '0;
        end
      end
`ifdef RSTCTRL_MAX_RETRY_EN
      S_FAIL: begin
        state_next = S_FAIL;
      end
`endif
      default: begin
        state_next = S_PLL_RST;
        cnt_next   = '0;
      end
    endcase
  end

  // Output flops are loaded from the next state so they change on the same edge as the state.
  always_comb begin
    pll_rst_next   = (state_next == S_PLL_RST);
`ifdef RSTCTRL_MAX_RETRY_EN
    pll_rst_next   = pll_rst_next || (state_next == S_FAIL);
`endif
    sys_rst_next   = (state_next != S_RUN);
    pll_ready_next = (state_next == S_RUN);
    lock_lost_next = (state_reg == S_RUN) && !locked_s;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg     <= S_PLL_RST;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      pll_rst_reg   <= 1'b1;
      sys_rst_reg   <= 1'b1;
      pll_ready_reg <= 1'b0;
      lock_lost_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      pll_rst_reg   <= pll_rst_next;
      sys_rst_reg   <= sys_rst_next;
      pll_ready_reg <= pll_ready_next;
      lock_lost_reg <= lock_lost_next;
    end
  end

`ifdef RSTCTRL_MAX_RETRY_EN
  logic fail_reg;

  always_ff @(posedge refclk) begin
    if (rst) begin
      fail_reg <= 1'b0;
    end else begin
      fail_reg <= (state_next == S_FAIL);
    end
  end

  assign fail = fail_reg;
`else
  logic [7:0] unused_max_retry;
  assign unused_max_retry = 8'(MAX_RETRY);
  assign fail             = 1'b0;
`endif

  assign pll_rst   = pll_rst_reg;
  assign sys_rst   = sys_rst_reg;
  assign pll_ready = pll_ready_reg;
  assign lock_lost = lock_lost_reg;
  assign retry_cnt = retry_reg;

endmodule

// File: tb/tb_pll_rs_reset_ctrl.sv
// tb_pll_rs_reset_ctrl: scenario tasks plus a randomized soak, all checked against a
// phase/elapsed-time reference model of the reset sequencing rules.
module tb_pll_rs_reset_ctrl;

  localparam int PULSE = 4;
  localparam int TO    = 50;
  localparam int STAB  = 8;
  localparam int SYNC  = 2;
  localparam int MAXR  = 3;
`ifdef RSTCTRL_MAX_RETRY_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam logic [12:0] RESET_VEC = 13'b1_1_0_0_0_00000000;

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst, sys_rst, pll_ready, lock_lost, fail;
  logic [7:0] retry_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  pll_rs_reset_ctrl #(
    .RST_PULSE_CYC(PULSE), .LOCK_TIMEOUT_CYC(TO), .LOCK_STABLE_CYC(STAB),
    .SYNC_STAGES(SYNC), .MAX_RETRY(MAXR)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .pll_rst(pll_rst), .sys_rst(sys_rst),
    .pll_ready(pll_ready), .lock_lost(lock_lost), .retry_cnt(retry_cnt), .fail(fail)
  );

  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=no_finish exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // Reference model: a phase plus cycles spent in it; the synchronizer is a delay queue.
  localparam int P_PULSE = 0, P_WAIT = 1, P_SETTLE = 2, P_RUN = 3, P_DEAD = 4;
  int m_phase   = P_PULSE;
  int m_elapsed = 0;
  int m_retries = 0;
  bit m_lost    = 1'b0;
  bit m_hist[$];

  function automatic void model_edge(bit r, bit l);
    bit ls;
    m_lost = 1'b0;
    if (r) begin
      m_phase = P_PULSE; m_elapsed = 0; m_retries = 0;
      m_hist = {};
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
      return;
    end
    ls = m_hist[0];
    void'(m_hist.pop_front());
    m_hist.push_back(l);
    case (m_phase)
      P_PULSE: begin
        m_elapsed++;
        if (m_elapsed == PULSE) begin m_phase = P_WAIT; m_elapsed = 0; end
      end
      P_WAIT: begin
        if (ls) begin
          m_phase = P_SETTLE; m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == TO) begin
            m_elapsed = 0;
            if (m_retries < 255) m_retries++;
            m_phase = (LIMIT_EN && m_retries == MAXR) ? P_DEAD : P_PULSE;
          end
        end
      end
      P_SETTLE: begin
        if (!ls) begin
          m_phase = P_WAIT; m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == STAB) begin m_phase = P_RUN; m_elapsed = 0; end
        end
      end
      P_RUN: begin
        if (!ls) begin m_lost = 1'b1; m_phase = P_PULSE; m_elapsed = 0; end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [12:0] model_vec();
    logic pr;
    pr = (m_phase == P_PULSE) || (m_phase == P_DEAD);
    return {pr, m_phase != P_RUN, m_phase == P_RUN, m_lost, m_phase == P_DEAD, 8'(m_retries)};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {pll_rst, sys_rst, pll_ready, lock_lost, fail, retry_cnt};
  endfunction

  task automatic step();
    @(posedge refclk);
    model_edge(rst, locked);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      locked = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (dut_vec() !== RESET_VEC) begin
        failures++;
        $display("FAIL reset_values cyc=%0d got=%b exp=%b", cyc, dut_vec(), RESET_VEC);
      end
    end
    $display("test_reset: outputs=%b", dut_vec());
  endtask

  task automatic test_nominal();
    int n, lat;
    rst = 1'b0; locked = 1'b0;
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      n++; step();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_nominal cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
    end
    checks++;
    if (n != PULSE) begin failures++; $display("FAIL nominal_pulse_width got=%0d exp=%0d", n, PULSE); end
    repeat (10 - n) begin
      step();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_nominal cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
    end
    locked = 1'b1;
    lat = 0;
    do begin
      step(); lat++;
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_nominal cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
    end while (sys_rst === 1'b1 && lat < 40);
    checks++;
    if (lat != SYNC + STAB + 1) begin failures++; $display("FAIL nominal_release_latency got=%0d exp=%0d", lat, SYNC + STAB + 1); end
    checks++;
    if (pll_ready !== 1'b1 || retry_cnt !== 8'd0) begin
      failures++; $display("FAIL nominal_run got=ready%b/retry%0d exp=ready1/retry0", pll_ready, retry_cnt);
    end
    $display("test_nominal: pulse=%0d release_latency=%0d", n, lat);
  endtask

  task automatic test_loss_in_run();
    int n, w, gap;
    logic [7:0] retry_before;
    retry_before = retry_cnt;
    locked = 1'b0;
    n = 0;
    do begin
      step(); n++;
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_loss cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
    end while (sys_rst === 1'b0 && n < 20);
    checks++;
    if (n != SYNC + 1) begin failures++; $display("FAIL loss_latency got=%0d exp=%0d", n, SYNC + 1); end
    checks++;
    if (lock_lost !== 1'b1) begin failures++; $display("FAIL loss_pulse_start got=%b exp=1", lock_lost); end
    w = 0;
    while (pll_rst === 1'b1 && w < 20) begin
      w++; step();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_loss cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
      if (w == 1) begin
        checks++;
        if (lock_lost !== 1'b0) begin failures++; $display("FAIL loss_pulse_single got=%b exp=0", lock_lost); end
      end
    end
    checks++;
    if (w != PULSE) begin failures++; $display("FAIL loss_pll_pulse_width got=%0d exp=%0d", w, PULSE); end
    gap = $urandom_range(0, 20);
    repeat (gap) begin
      step();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_loss cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
    end
    locked = 1'b1;
    n = 0;
    while (pll_ready !== 1'b1 && n < 200) begin
      n++; step();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_loss cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
    end
    checks++;
    if (pll_ready !== 1'b1 || retry_cnt !== retry_before) begin
      failures++; $display("FAIL loss_recover got=ready%b/retry%0d exp=ready1/retry%0d", pll_ready, retry_cnt, retry_before);
    end
    $display("test_loss_in_run: latency=3 pulse=%0d relock_gap=%0d", w, gap);
  endtask

  task automatic test_glitch();
    int k, n;
    for (int it = 0; it < 3; it++) begin
      rst = 1'b1; locked = 1'b0;
      step();
      rst = 1'b0;
      n = 0;
      while (pll_rst === 1'b1 && n < 20) begin
        n++; step();
        checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_glitch cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
      end
      k = (it == 0) ? 5 : int'($urandom_range(1, 8));
      locked = 1'b1;
      repeat (k) begin
        step();
        checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_glitch cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
      end
      locked = 1'b0;
      step();
      locked = 1'b1;
      n = 0;
      do begin
        step(); n++;
        checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_glitch cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
      end while (sys_rst === 1'b1 && n < 60);
      checks++;
      if (n != SYNC + STAB + 1) begin failures++; $display("FAIL glitch_new_window got=%0d exp=%0d", n, SYNC + STAB + 1); end
      checks++;
      if (retry_cnt !== 8'd0) begin failures++; $display("FAIL glitch_no_retry got=%0d exp=0", retry_cnt); end
      $display("test_glitch: high_before_glitch=%0d latency_after=%0d", k, n);
    end
  endtask

  task automatic test_timeout();
    int lo, hi;
    rst = 1'b1; locked = 1'b0;
    step();
    rst = 1'b0;
    hi = 0;
    while (pll_rst === 1'b1 && hi < 20) begin hi++; step(); end
    for (int i = 1; i <= 3; i++) begin
      lo = 0;
      while (pll_rst === 1'b0 && lo < 200) begin
        lo++; step();
        checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_timeout cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
      end
      checks++;
      if (lo != TO) begin failures++; $display("FAIL timeout_wait_len got=%0d exp=%0d", lo, TO); end
      checks++;
      if (retry_cnt !== 8'(i) || sys_rst !== 1'b1) begin
        failures++; $display("FAIL timeout_retry got=retry%0d/sys%b exp=retry%0d/sys1", retry_cnt, sys_rst, i);
      end
`ifdef RSTCTRL_MAX_RETRY_EN
      if (i == MAXR) begin
        checks++;
        if (fail !== 1'b1) begin failures++; $display("FAIL timeout_fail_flag got=%b exp=1", fail); end
        for (int c = 0; c < 30; c++) begin
          locked = (c >= 5);
          step();
          checks++;
          if (pll_rst !== 1'b1 || fail !== 1'b1 || sys_rst !== 1'b1 || pll_ready !== 1'b0) begin
            failures++; $display("FAIL fail_terminal cyc=%0d got=%b exp=1_1_0_x_1", cyc, dut_vec());
          end
        end
      end else
`endif
      begin
        hi = 0;
        while (pll_rst === 1'b1 && hi < 20) begin
          hi++; step();
          checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_timeout cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
        end
        checks++;
        if (hi != PULSE) begin failures++; $display("FAIL timeout_pulse_width got=%0d exp=%0d", hi, PULSE); end
      end
      $display("test_timeout: attempt=%0d wait=%0d retry=%0d", i, lo, retry_cnt);
    end
  endtask

  task automatic test_reset_mid_stable();
    int n;
    rst = 1'b1; locked = 1'b0;
    step();
    rst = 1'b0;
    n = 0;
    while (retry_cnt !== 8'd1 && n < 200) begin
      n++; step();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_midrst cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
    end
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin n++; step(); end
    locked = 1'b1;
    repeat (SYNC + 4) begin
      step();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_midrst cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (dut_vec() !== RESET_VEC) begin failures++; $display("FAIL midrst_values got=%b exp=%b", dut_vec(), RESET_VEC); end
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      n++; step();
      checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_midrst cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
    end
    checks++;
    if (n != PULSE) begin failures++; $display("FAIL midrst_restart_pulse got=%0d exp=%0d", n, PULSE); end
    $display("test_reset_mid_stable: restart_pulse=%0d", n);
  endtask

  task automatic test_soak();
    int hold;
    for (int seg = 0; seg < 80; seg++) begin
      locked = 1'($urandom_range(0, 3) != 0);
      hold   = $urandom_range(1, 70);
      for (int c = 0; c < hold; c++) begin
        rst = ($urandom_range(0, 199) == 0);
        step();
        checks++; if (dut_vec() !== model_vec()) begin failures++; $display("FAIL model_soak cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec()); end
      end
    end
    rst = 1'b0;
    $display("test_soak: cycles=%0d retry=%0d", cyc, retry_cnt);
  endtask

  initial begin
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    test_reset();
    test_nominal();
    test_loss_in_run();
    test_glitch();
    test_timeout();
    test_reset_mid_stable();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
